// File: rtl/hilo_multu.sv
// hilo_multu: sequential 32-step shift-add unsigned multiplier with HI/LO
// registers, serving MULTU, MFHI and MFLO for the MIPS execute stage.
module hilo_multu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               is_multu;
    logic               is_mfhi;
    logic               is_mflo;
    logic               accept;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product_nxt;

    assign is_multu = (Signal == FN_MULTU);
    assign is_mfhi  = (Signal == FN_MFHI);
    assign is_mflo  = (Signal == FN_MFLO);

    // Status flags come straight off the state register.
    assign busy  = (state == MUL);
    assign done  = (state == DONE);

    // Only our own function codes are refused while a multiply runs.
    assign stall  = valid & busy & (is_multu | is_mfhi | is_mflo);
    assign accept = valid & ((state == IDLE) | (state == DONE));

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping the carry), then shift the whole product right by one.
    always_comb begin
        addend      = product[0] ? {1'b0, mcand} : '0;
        sum         = {1'b0, product[2*WIDTH-1:WIDTH]} + addend;
        product_nxt = {sum, product[WIDTH-1:1]};
    end

    // Control FSM, multiply datapath, HI/LO and read-port registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            mcand   <= '0;
            product <= '0;
            hi      <= '0;
            lo      <= '0;
            dataOut <= '0;
        end else begin
            // In DONE, hi/lo already hold the new product, so reads see it.
            if (accept && is_mfhi) dataOut <= hi;
            if (accept && is_mflo) dataOut <= lo;

            case (state)
                IDLE, DONE: begin
                    if (accept && is_multu) begin
                        mcand   <= dataA;
                        product <= {{WIDTH{1'b0}}, dataB};
                        counter <= '0;
                        state   <= MUL;
                    end else begin
                        state   <= IDLE;
                    end
                end
                MUL: begin
                    product <= product_nxt;
                    counter <= counter + CW'(1);
                    if (counter == LAST_STEP) begin
                        hi    <= product_nxt[2*WIDTH-1:WIDTH];
                        lo    <= product_nxt[WIDTH-1:0];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_multu.sv
// tb_hilo_multu: directed vectors with hand-computed products for hilo_multu.
module tb_hilo_multu;

    localparam int W = 32;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [5:0]   Signal;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [W-1:0] dataOut;
    logic         busy;
    logic         done;
    logic         stall;

    int n_checks = 0;
    int n_errors = 0;

    hilo_multu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; everything after this sits 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        valid  = 1'b0;
        Signal = 6'b0;
    endtask

    // Issue a MULTU for one edge; returns in cycle 1 after the accept.
    task automatic issue_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        valid  = 1'b1;
        Signal = FN_MULTU;
        dataA  = a;
        dataB  = b;
        step();
        idle_bus();
    endtask

    // Called in cycle 1 after an accept; stops in the DONE cycle (or on timeout).
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 60) begin
            if (busy) bcnt++;
            step();
            cyc++;
        end
    endtask

    task automatic read_reg(input logic [5:0] fn, output logic [W-1:0] val);
        valid  = 1'b1;
        Signal = fn;
        step();
        idle_bus();
        val = dataOut;
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int cyc, bcnt;
        logic [W-1:0] v;
        issue_mul(a, b);
        wait_done(cyc, bcnt);
        check({tag, "_done_cycle"}, 64'(cyc), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd32);
        read_reg(FN_MFHI, v);
        check({tag, "_hi"}, 64'(v), 64'(ehi));
        read_reg(FN_MFLO, v);
        check({tag, "_lo"}, 64'(v), 64'(elo));
    endtask

    initial begin
        int cyc, bcnt, dcnt;
        logic [W-1:0] v;

        rst_n = 1'b0;
        dataA = '0;
        dataB = '0;
        // Reset wins over a simultaneous valid MULTU.
        valid  = 1'b1;
        Signal = FN_MULTU;
        dataA  = 32'd5;
        dataB  = 32'd5;
        step();
        step();
        idle_bus();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dataout", 64'(dataOut), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        step();
        read_reg(FN_MFHI, v);
        check("rst_hi", 64'(v), 64'd0);
        read_reg(FN_MFLO, v);
        check("rst_lo", 64'(v), 64'd0);

        // Basic products and carry boundaries.
        run_mul("m7x6", 32'd7, 32'd6, 32'd0, 32'd42);
        run_mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mul("m80x2", 32'h8000_0000, 32'd2, 32'd1, 32'd0);
        run_mul("m0x1234", 32'd0, 32'h1234_5678, 32'd0, 32'd0);
        run_mul("mffx2", 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

        // MFLO held through a 3x5 multiply: stalled in cycles 1..32.
        issue_mul(32'd3, 32'd5);
        valid  = 1'b1;
        Signal = FN_MFLO;
        dcnt   = 0;
        for (int c = 1; c <= 32; c++) begin
            if (stall !== 1'b1) dcnt++;
            step();
        end
        check("held_stall_cycles_bad", 64'(dcnt), 64'd0);
        check("held_stall_drop", 64'(stall), 64'd0);
        check("held_done", 64'(done), 64'd1);
        step();
        idle_bus();
        check("held_mflo", 64'(dataOut), 64'd15);

        // An unrelated code while busy is never stalled and changes nothing.
        issue_mul(32'd5, 32'd5);
        valid  = 1'b1;
        Signal = FN_ADD;
        dataA  = 32'd99;
        dataB  = 32'd99;
        step();
        check("add_stall", 64'(stall), 64'd0);
        check("add_busy", 64'(busy), 64'd1);
        step();
        idle_bus();
        check("add_dataout", 64'(dataOut), 64'd15);
        wait_done(cyc, bcnt);
        check("add_done_cycle", 64'(cyc), 64'd31);
        read_reg(FN_MFLO, v);
        check("add_lo", 64'(v), 64'd25);

        // Back-to-back: second MULTU accepted in the first DONE cycle.
        issue_mul(32'd10, 32'd10);
        wait_done(cyc, bcnt);
        check("b2b_first_done", 64'(done), 64'd1);
        issue_mul(32'd2, 32'd3);
        check("b2b_rebusy", 64'(busy), 64'd1);
        check("b2b_nodone", 64'(done), 64'd0);
        step();
        step();
        valid  = 1'b1;
        Signal = FN_MFLO;
        #1;
        check("b2b_mid_stall", 64'(stall), 64'd1);
        cyc = 3;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        check("b2b_done_cycle", 64'(cyc), 64'd33);
        check("b2b_stall_drop", 64'(stall), 64'd0);
        step();
        idle_bus();
        check("b2b_lo", 64'(dataOut), 64'd6);
        read_reg(FN_MFHI, v);
        check("b2b_hi", 64'(v), 64'd0);

        // Reset in the middle of a multiply discards it.
        issue_mul(32'd7, 32'd6);
        for (int c = 1; c < 10; c++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_dataout", 64'(dataOut), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcnt++;
            step();
        end
        check("mrst_no_done", 64'(dcnt), 64'd0);
        read_reg(FN_MFHI, v);
        check("mrst_hi", 64'(v), 64'd0);
        read_reg(FN_MFLO, v);
        check("mrst_lo", 64'(v), 64'd0);
        run_mul("m4x4", 32'd4, 32'd4, 32'd0, 32'd16);

        // MULTU 9x9 held stalled behind a running 2x2, accepted in DONE.
        issue_mul(32'd2, 32'd2);
        valid  = 1'b1;
        Signal = FN_MULTU;
        dataA  = 32'd9;
        dataB  = 32'd9;
        #1;
        check("q_stall", 64'(stall), 64'd1);
        wait_done(cyc, bcnt);
        check("q_first_done", 64'(cyc), 64'd33);
        check("q_stall_drop", 64'(stall), 64'd0);
        step();
        idle_bus();
        check("q_rebusy", 64'(busy), 64'd1);
        wait_done(cyc, bcnt);
        check("q_second_done", 64'(cyc), 64'd33);
        read_reg(FN_MFHI, v);
        check("q_hi", 64'(v), 64'd0);
        read_reg(FN_MFLO, v);
        check("q_lo", 64'(v), 64'd81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
